// File: rtl/lke_ctrl_pkg.sv
// Shared constants for the lookup-engine control path: header layout,
// module ids, tuser length field and the packet generator state type.
package lke_ctrl_pkg;

    localparam logic [7:0] CTRL_MAGIC_DEFAULT = 8'hF1;

    // Header beat field placement (bit offsets / widths within tdata).
    localparam int HDR_MAGIC_LSB = 0;
    localparam int HDR_MAGIC_W   = 8;
    localparam int HDR_STAGE_LSB = 8;
    localparam int HDR_STAGE_W   = 5;
    localparam int HDR_MOD_LSB   = 13;
    localparam int HDR_MOD_W     = 4;
    localparam int HDR_INDEX_LSB = 24;
    localparam int HDR_INDEX_W   = 8;
    localparam int HDR_BEATS_LSB = 32;
    localparam int HDR_BEATS_W   = 16;

    // Target module ids (match LOOKUP_ID of the table in each stage).
    localparam logic [3:0] MOD_ID_CAM     = 4'd0;
    localparam logic [3:0] MOD_ID_ACT_RAM = 4'd1;

    // Packet length in bytes is carried in the low tuser bits.
    localparam int TUSER_LEN_LSB = 0;
    localparam int TUSER_LEN_W   = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_PAY  = 2'd2
    } pkt_state_e;

endpackage

// File: rtl/lke_ctrl_pkt_gen.sv
// Control packet generator: turns one table-entry write request into an
// AXI-stream packet (header beat + payload beats). All stream outputs are
// registered; they are computed from the next-state values so the header
// appears the cycle after the request is accepted.
// Handshake: a beat transfers on a clock edge where tvalid && tready; while
// tvalid && !tready every stream output holds, and tvalid stays high until
// the beat transfers. A request transfers on req_valid && req_ready.
module lke_ctrl_pkt_gen
    import lke_ctrl_pkg::*;
#(
    parameter int         C_S_AXIS_DATA_WIDTH  = 256,
    parameter int         C_S_AXIS_TUSER_WIDTH = 128,
    parameter int         ENTRY_WIDTH          = 625,
    parameter logic [7:0] CTRL_MAGIC           = CTRL_MAGIC_DEFAULT
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 req_valid,
    output logic                                 req_ready,
    input  logic [4:0]                           req_stage,
    input  logic [3:0]                           req_mod_id,
    input  logic [7:0]                           req_index,
    input  logic [ENTRY_WIDTH-1:0]               req_data,
    output logic [C_S_AXIS_DATA_WIDTH-1:0]       c_m_axis_tdata,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]      c_m_axis_tuser,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]     c_m_axis_tkeep,
    output logic                                 c_m_axis_tvalid,
    output logic                                 c_m_axis_tlast,
    input  logic                                 c_m_axis_tready,
    output logic                                 pkt_done,
    output logic [15:0]                          pkt_count,
    output pkt_state_e                           dbg_state
);

    localparam int DW          = C_S_AXIS_DATA_WIDTH;
    localparam int UW          = C_S_AXIS_TUSER_WIDTH;
    localparam int KW          = DW / 8;
    localparam int PAY_BEATS   = (ENTRY_WIDTH + DW - 1) / DW;
    localparam int ENTRY_BYTES = (ENTRY_WIDTH + 7) / 8;
    localparam int TOTAL_BYTES = KW + ENTRY_BYTES;
    localparam int LB          = ENTRY_BYTES - (PAY_BEATS - 1) * KW;
    localparam int BCW         = (PAY_BEATS > 1) ? $clog2(PAY_BEATS) : 1;
    localparam int PAD_W       = PAY_BEATS * DW;

    localparam logic [KW-1:0]  KEEP_ALL  = {KW{1'b1}};
    localparam logic [KW-1:0]  KEEP_LAST = KEEP_ALL >> (KW - LB);
    localparam logic [BCW-1:0] LAST_BEAT = BCW'(PAY_BEATS - 1);

    pkt_state_e             state_q, state_d;
    logic [BCW-1:0]         beat_cnt_q, beat_cnt_d;
    logic [4:0]             stage_q, stage_d;
    logic [3:0]             mod_q, mod_d;
    logic [7:0]             index_q, index_d;
    logic [ENTRY_WIDTH-1:0] data_q, data_d;
    logic [DW-1:0]          tdata_q, tdata_d;
    logic [UW-1:0]          tuser_q, tuser_d;
    logic [KW-1:0]          tkeep_q, tkeep_d;
    logic                   tlast_q, tlast_d;
    logic                   tvalid_q, tvalid_d;
    logic                   done_q, done_d;
    logic [15:0]            count_q, count_d;
    logic                   ready_q, ready_d;
    logic [PAD_W-1:0]       data_pad_d;

    assign data_pad_d = PAD_W'(data_d);

    // Next state, request capture, beat counter and packet counter.
    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        stage_d    = stage_q;
        mod_d      = mod_q;
        index_d    = index_q;
        data_d     = data_q;
        count_d    = count_q;
        done_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid && ready_q) begin
                    stage_d = req_stage;
                    mod_d   = req_mod_id;
                    index_d = req_index;
                    data_d  = req_data;
                    state_d = ST_HDR;
                end
            end
            ST_HDR: begin
                if (c_m_axis_tready) begin
                    state_d    = ST_PAY;
                    beat_cnt_d = '0;
                end
            end
            ST_PAY: begin
                if (c_m_axis_tready) begin
                    if (beat_cnt_q == LAST_BEAT) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                        count_d = count_q + 16'd1;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Registered-output values for the beat that will be presented next.
    always_comb begin
        tdata_d  = '0;
        tuser_d  = '0;
        tkeep_d  = '0;
        tlast_d  = 1'b0;
        tvalid_d = (state_d != ST_IDLE);
        ready_d  = (state_d == ST_IDLE);
        if (state_d != ST_IDLE) begin
            tuser_d[TUSER_LEN_LSB +: TUSER_LEN_W] = TUSER_LEN_W'(TOTAL_BYTES);
        end
        if (state_d == ST_HDR) begin
            tdata_d[HDR_MAGIC_LSB +: HDR_MAGIC_W] = CTRL_MAGIC;
            tdata_d[HDR_STAGE_LSB +: HDR_STAGE_W] = stage_d;
            tdata_d[HDR_MOD_LSB   +: HDR_MOD_W]   = mod_d;
            tdata_d[HDR_INDEX_LSB +: HDR_INDEX_W] = index_d;
            tdata_d[HDR_BEATS_LSB +: HDR_BEATS_W] = HDR_BEATS_W'(PAY_BEATS);
            tkeep_d = KEEP_ALL;
        end else if (state_d == ST_PAY) begin
            tdata_d = data_pad_d[int'(beat_cnt_d) * DW +: DW];
            tlast_d = (beat_cnt_d == LAST_BEAT);
            tkeep_d = tlast_d ? KEEP_LAST : KEEP_ALL;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            beat_cnt_q <= '0;
            stage_q    <= '0;
            mod_q      <= '0;
            index_q    <= '0;
            data_q     <= '0;
            tdata_q    <= '0;
            tuser_q    <= '0;
            tkeep_q    <= '0;
            tlast_q    <= 1'b0;
            tvalid_q   <= 1'b0;
            done_q     <= 1'b0;
            count_q    <= '0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            stage_q    <= stage_d;
            mod_q      <= mod_d;
            index_q    <= index_d;
            data_q     <= data_d;
            tdata_q    <= tdata_d;
            tuser_q    <= tuser_d;
            tkeep_q    <= tkeep_d;
            tlast_q    <= tlast_d;
            tvalid_q   <= tvalid_d;
            done_q     <= done_d;
            count_q    <= count_d;
            ready_q    <= ready_d;
        end
    end

    assign req_ready       = ready_q;
    assign c_m_axis_tdata  = tdata_q;
    assign c_m_axis_tuser  = tuser_q;
    assign c_m_axis_tkeep  = tkeep_q;
    assign c_m_axis_tvalid = tvalid_q;
    assign c_m_axis_tlast  = tlast_q;
    assign pkt_done        = done_q;
    assign pkt_count       = count_q;
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_lke_ctrl_pkt_gen.sv
// Bench for lke_ctrl_pkt_gen: directed requests, a packet-level reference
// model feeding an expected-beat queue, and one per-cycle compare process.
module tb_lke_ctrl_pkt_gen;
    import lke_ctrl_pkg::*;

    localparam int DW     = 256;
    localparam int UW     = 128;
    localparam int EW     = 625;
    localparam int KW     = DW / 8;
    localparam int BEAT_W = DW + KW + 1 + UW;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [4:0]    req_stage = '0;
    logic [3:0]    req_mod_id = '0;
    logic [7:0]    req_index = '0;
    logic [EW-1:0] req_data = '0;
    logic [DW-1:0] tdata;
    logic [UW-1:0] tuser;
    logic [KW-1:0] tkeep;
    logic          tvalid, tlast;
    logic          tready = 1'b1;
    logic          pkt_done;
    logic [15:0]   pkt_count;
    pkt_state_e    dbg_state;

    lke_ctrl_pkt_gen dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_stage       (req_stage),
        .req_mod_id      (req_mod_id),
        .req_index       (req_index),
        .req_data        (req_data),
        .c_m_axis_tdata  (tdata),
        .c_m_axis_tuser  (tuser),
        .c_m_axis_tkeep  (tkeep),
        .c_m_axis_tvalid (tvalid),
        .c_m_axis_tlast  (tlast),
        .c_m_axis_tready (tready),
        .pkt_done        (pkt_done),
        .pkt_count       (pkt_count),
        .dbg_state       (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int failures = 0;
    logic [BEAT_W-1:0] exp_q[$];
    logic [BEAT_W-1:0] obs_q[$];
    bit          mon_en = 1'b0;
    bit          b2b_mode = 1'b0;
    bit          stall_mode = 1'b0;
    bit          done_pend = 1'b0;
    bit          prev_stall = 1'b0;
    bit          prev_tvalid = 1'b0;
    logic [15:0] model_count = '0;
    int          cyc = 0;
    int          last_acc_cyc = -1;

    task automatic chk(input string name, input logic [BEAT_W-1:0] act, input logic [BEAT_W-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference model: whole packet from the request fields.
    function automatic void push_packet(input logic [4:0] st, input logic [3:0] md,
                                        input logic [7:0] ix, input logic [EW-1:0] d);
        int pay_beats = (EW + DW - 1) / DW;
        int entry_bytes = (EW + 7) / 8;
        int total = KW + entry_bytes;
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic [UW-1:0] user;
        user = '0;
        user[15:0] = 16'(total);
        data = '0;
        data[7:0]   = 8'hF1;
        data[12:8]  = st;
        data[16:13] = md;
        data[31:24] = ix;
        data[47:32] = 16'(pay_beats);
        exp_q.push_back({data, {KW{1'b1}}, 1'b0, user});
        for (int b = 0; b < pay_beats; b++) begin
            data = '0;
            keep = '0;
            for (int i = 0; i < DW; i++)
                if (b * DW + i < EW) data[i] = d[b * DW + i];
            for (int j = 0; j < KW; j++)
                keep[j] = (b * KW + j < entry_bytes);
            exp_q.push_back({data, keep, (b == pay_beats - 1), user});
        end
    endfunction

    // ---------------- tready driver ----------------
    always @(posedge clk) begin
        #1;
        tready = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        logic [BEAT_W-1:0] cur;
        logic [BEAT_W-1:0] expb;
        bit acc_last;
        cyc++;
        acc_last = 1'b0;
        cur = {tdata, tkeep, tlast, tuser};
        if (!mon_en) begin
            done_pend = 1'b0;
            prev_stall = 1'b0;
            prev_tvalid = 1'b0;
        end else begin
            chk("pkt_count", BEAT_W'(pkt_count), BEAT_W'(model_count));
            chk("pkt_done", BEAT_W'(pkt_done), BEAT_W'(done_pend));
            if (prev_stall) chk("tvalid_held", BEAT_W'(tvalid), BEAT_W'(1));
            if (tvalid) begin
                if (b2b_mode && !prev_tvalid && last_acc_cyc >= 0)
                    chk("b2b_gap", BEAT_W'(cyc - last_acc_cyc), BEAT_W'(2));
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", BEAT_W'(tvalid), BEAT_W'(0));
                end else begin
                    expb = exp_q[0];
                    chk("beat", cur, expb);
                    if (tready) begin
                        obs_q.push_back(cur);
                        void'(exp_q.pop_front());
                        acc_last = expb[UW];
                    end
                end
            end else begin
                chk("idle_outputs", cur, '0);
            end
            done_pend = acc_last;
            if (acc_last) begin
                model_count = model_count + 16'd1;
                last_acc_cyc = cyc;
            end
            prev_tvalid = tvalid;
            prev_stall = tvalid && !tready;
        end
    end

    // ---------------- driver tasks ----------------
    // Called at posedge+1; leaves req_valid high, returns at posedge+1 after acceptance.
    task automatic send_req(input logic [4:0] st, input logic [3:0] md,
                            input logic [7:0] ix, input logic [EW-1:0] d);
        int t = 0;
        req_stage = st;
        req_mod_id = md;
        req_index = ix;
        req_data = d;
        req_valid = 1'b1;
        @(negedge clk);
        while (!req_ready && t < 200) begin
            t++;
            @(negedge clk);
        end
        if (!req_ready) chk("req_accept_timeout", BEAT_W'(req_ready), BEAT_W'(1));
        else push_packet(st, md, ix, d);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 500) begin
            t++;
            @(posedge clk);
        end
        chk("drain_timeout", BEAT_W'(exp_q.size()), BEAT_W'(0));
        repeat (3) @(posedge clk);
        #1;
    endtask

    function automatic logic [EW-1:0] byte_pattern(input int seed);
        logic [EW-1:0] d;
        for (int k = 0; k < EW; k++) d[k] = 1'(((k / 8 + seed) & 255) >> (k % 8));
        return d;
    endfunction

    // ---------------- directed sequence ----------------
    initial begin
        logic [BEAT_W-1:0] b;
        logic [EW-1:0] pat1;
        pat1 = byte_pattern(0);

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", BEAT_W'(req_ready), BEAT_W'(0));
        chk("rst_outputs", {tdata, tkeep, tlast, tuser}, '0);
        chk("rst_tvalid", BEAT_W'(tvalid), BEAT_W'(0));
        chk("rst_pkt_done", BEAT_W'(pkt_done), BEAT_W'(0));
        chk("rst_pkt_count", BEAT_W'(pkt_count), BEAT_W'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1 mon_en = 1'b1;
        @(negedge clk);
        chk("post_rst_req_ready", BEAT_W'(req_ready), BEAT_W'(1));
        @(posedge clk);
        #1;

        // Basic packet, literal pins on the model.
        obs_q.delete();
        send_req(5'd3, 4'd2, 8'h05, pat1);
        req_valid = 1'b0;
        wait_drain();
        chk("basic_beats", BEAT_W'(obs_q.size()), BEAT_W'(4));
        if (obs_q.size() == 4) begin
            b = obs_q[0];
            // {16'd3, 8'h05, 7'b0, 4'd2, 5'd3, 8'hF1}
            chk("hdr_tdata", BEAT_W'(b[BEAT_W-DW +: 48]), BEAT_W'(48'h0003_0500_43F1));
            chk("hdr_tuser", BEAT_W'(b[15:0]), BEAT_W'(16'h006F));
            b = obs_q[1];
            chk("beat1_low", BEAT_W'(b[BEAT_W-DW +: 32]), BEAT_W'(32'h0302_0100));
            b = obs_q[3];
            chk("beat3_tkeep", BEAT_W'(b[UW+1 +: KW]), BEAT_W'(32'h0000_7FFF));
            chk("beat3_low", BEAT_W'(b[BEAT_W-DW +: 128]),
                BEAT_W'(128'h0000_4D4C_4B4A_4948_4746_4544_4342_4140));
            chk("beat3_high", BEAT_W'(b[BEAT_W-1 -: 128]), BEAT_W'(0));
            chk("tlast_pattern", BEAT_W'({obs_q[3][UW], obs_q[2][UW], obs_q[1][UW], obs_q[0][UW]}),
                BEAT_W'(4'b1000));
        end
        chk("basic_pkt_count", BEAT_W'(pkt_count), BEAT_W'(1));

        // Random backpressure.
        stall_mode = 1'b1;
        obs_q.delete();
        send_req(5'd17, MOD_ID_CAM, 8'hA7, byte_pattern(37));
        req_valid = 1'b0;
        send_req(5'd31, MOD_ID_ACT_RAM, 8'hFF, {EW{1'b1}});
        req_valid = 1'b0;
        wait_drain();
        stall_mode = 1'b0;
        chk("stall_beats", BEAT_W'(obs_q.size()), BEAT_W'(8));
        chk("stall_pkt_count", BEAT_W'(pkt_count), BEAT_W'(3));

        // Reset during the first payload beat.
        send_req(5'd9, 4'd7, 8'h42, byte_pattern(99));
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        mon_en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_tvalid", BEAT_W'(tvalid), BEAT_W'(0));
        chk("midrst_tlast", BEAT_W'(tlast), BEAT_W'(0));
        chk("midrst_req_ready", BEAT_W'(req_ready), BEAT_W'(0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        exp_q.delete();
        model_count = '0;
        @(posedge clk);
        #1 mon_en = 1'b1;
        @(negedge clk);
        chk("midrst_post_ready", BEAT_W'(req_ready), BEAT_W'(1));
        chk("midrst_post_count", BEAT_W'(pkt_count), BEAT_W'(0));
        @(posedge clk);
        #1;

        // Back-to-back requests with req_valid held high.
        last_acc_cyc = -1;
        b2b_mode = 1'b1;
        obs_q.delete();
        send_req(5'd1, MOD_ID_CAM, 8'h10, byte_pattern(5));
        send_req(5'd2, MOD_ID_ACT_RAM, 8'h20, byte_pattern(6));
        send_req(5'd4, 4'd3, 8'h30, byte_pattern(7));
        req_valid = 1'b0;
        wait_drain();
        b2b_mode = 1'b0;
        chk("b2b_beats", BEAT_W'(obs_q.size()), BEAT_W'(12));
        chk("b2b_pkt_count", BEAT_W'(pkt_count), BEAT_W'(3));

        // Counter wrap.
        force dut.count_q = 16'hFFFF;
        model_count = 16'hFFFF;
        @(posedge clk);
        #1 release dut.count_q;
        @(negedge clk);
        chk("wrap_preset", BEAT_W'(pkt_count), BEAT_W'(16'hFFFF));
        @(posedge clk);
        #1;
        send_req(5'd6, 4'd1, 8'h77, byte_pattern(200));
        req_valid = 1'b0;
        wait_drain();
        chk("wrap_pkt_count", BEAT_W'(pkt_count), BEAT_W'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
